// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one single-ported unified memory between the instruction-fetch (IF)
// and data-memory (MEM) pipeline stages. Accesses are serialized by a small
// non-preemptive FSM. A pending data access always wins over a pending fetch
// at the moment of grant.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr/if_flush    fetch requester (flush discards the in-flight result)
//   mem_req/mem_we/mem_addr/
//   mem_wdata                  data requester
//   if_rdata/if_done           fetch response (done is a one-cycle pulse)
//   mem_rdata/mem_done         data response (done is a one-cycle pulse)
//   stall_if/stall_mem         combinational stage stalls: req & ~done
//   ram_req/ram_we/ram_addr/
//   ram_wdata                  registered memory request, held until ack
//   ram_rdata/ram_ack          memory response
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  state_e            state_q;
  logic              ram_req_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic              drop_q;      // in-flight fetch result is to be discarded

  // Arbitration FSM with all outputs registered; the done flags set on the
  // ack edge double as the record of which requester owns the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= {ADDR_W{1'b0}};
      ram_wdata_q <= {DATA_W{1'b0}};
      if_rdata_q  <= {DATA_W{1'b0}};
      mem_rdata_q <= {DATA_W{1'b0}};
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          drop_q <= 1'b0;
          if (mem_req) begin
            // data side has fixed priority, even with a fetch also pending
            ram_req_q   <= 1'b1;
            ram_we_q    <= mem_we;
            ram_addr_q  <= mem_addr;
            ram_wdata_q <= mem_wdata;
            state_q     <= ST_BUSY_MEM;
          end else if (if_req) begin
            ram_req_q  <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= if_addr;
            state_q    <= ST_BUSY_IF;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY_IF: begin
          if (ram_ack) begin
            // a flush arriving together with the ack still suppresses done
            if_rdata_q <= ram_rdata;
            if_done_q  <= ~(drop_q | if_flush);
            ram_req_q  <= 1'b0;
            state_q    <= ST_RESP;
          end else if (if_flush) begin
            drop_q <= 1'b1;
          end else begin
            state_q <= ST_BUSY_IF;
          end
        end
        ST_BUSY_MEM: begin
          if (ram_ack) begin
            mem_rdata_q <= ram_rdata;
            mem_done_q  <= 1'b1;
            ram_req_q   <= 1'b0;
            state_q     <= ST_RESP;
          end else begin
            state_q <= ST_BUSY_MEM;
          end
        end
        ST_RESP: begin
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
          drop_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          ram_req_q  <= 1'b0;
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
          drop_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;

  // Stalls drop in the done cycle so the stage advances on that edge.
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A transaction-level schedule model
// decides, from the grant rules, when each access is granted, when the
// memory request window and the done pulse fall, and which data comes back.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] if_rdata;
  logic        if_done;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stall_if;
  logic        stall_mem;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_rdata(if_rdata), .if_done(if_done), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // transaction schedule model: who (0 none, 1 IF, 2 MEM), grant cycle, waits
  int          t_who   = 0;
  int          t_g     = 0;
  int          t_w     = 0;
  logic        t_we    = 1'b0;
  logic        t_drop  = 1'b0;
  logic [31:0] t_addr  = 32'h0;
  logic [31:0] t_wdata = 32'h0;
  logic [31:0] t_data  = 32'h0;
  int          free_at = 0;
  int          force_w = -1;

  logic if_pend  = 1'b0;
  logic mem_pend = 1'b0;
  logic gen_en   = 1'b1;
  logic exp_if_done  = 1'b0;
  logic exp_mem_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // registered outputs observed just after the edge that opens cycle cyc
  task automatic check_regs();
    logic in_win;
    in_win = (t_who != 0) && (cyc >= t_g + 1) && (cyc <= t_g + 1 + t_w);
    exp_if_done  = (t_who == 1) && (cyc == t_g + 2 + t_w) && !t_drop;
    exp_mem_done = (t_who == 2) && (cyc == t_g + 2 + t_w);
    check_eq("ram_req", {31'd0, ram_req}, {31'd0, in_win});
    if (in_win) begin
      check_eq("ram_we", {31'd0, ram_we}, {31'd0, t_we});
      check_eq("ram_addr", ram_addr, t_addr);
      if (t_we) check_eq("ram_wdata", ram_wdata, t_wdata);
    end
    check_eq("if_done", {31'd0, if_done}, {31'd0, exp_if_done});
    check_eq("mem_done", {31'd0, mem_done}, {31'd0, exp_mem_done});
    if (exp_if_done) check_eq("if_rdata", if_rdata, t_data);
    if (exp_mem_done && !t_we) check_eq("mem_rdata", mem_rdata, t_data);
  endtask

  // requesters, grant model, memory responder and flush tracking for cycle cyc
  task automatic drive_cycle();
    if (t_who == 1 && cyc == t_g + 3 + t_w && !t_drop) if_pend = 1'b0;
    if (t_who == 2 && cyc == t_g + 3 + t_w) mem_pend = 1'b0;
    if (gen_en) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        if_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      end
      if (!mem_pend && $urandom_range(0, 3) == 0) begin
        mem_pend  = 1'b1;
        mem_we    = $urandom_range(0, 1) == 1;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end
    end
    if_req   = if_pend;
    mem_req  = mem_pend;
    if_flush = gen_en && if_pend && ($urandom_range(0, 5) == 0);
    if (if_flush) if_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};

    if (cyc >= free_at && (mem_req || if_req)) begin
      t_g    = cyc;
      t_w    = (force_w >= 0) ? force_w : $urandom_range(0, 3);
      t_drop = 1'b0;
      t_data = $urandom;
      if (mem_req) begin
        t_who = 2; t_we = mem_we; t_addr = mem_addr; t_wdata = mem_wdata;
      end else begin
        t_who = 1; t_we = 1'b0; t_addr = if_addr;
      end
      free_at = t_g + 3 + t_w;
    end

    if (t_who != 0 && cyc == t_g + 1 + t_w) begin
      ram_ack = 1'b1; ram_rdata = t_data;
    end else if (t_who != 0 && cyc > t_g && cyc < t_g + 1 + t_w) begin
      ram_ack = 1'b0; ram_rdata = $urandom;
    end else begin
      // stray acks outside an access must be ignored
      ram_ack = gen_en && ($urandom_range(0, 3) == 0); ram_rdata = $urandom;
    end

    if (t_who == 1 && if_flush && cyc >= t_g + 1 && cyc <= t_g + 1 + t_w) t_drop = 1'b1;

    #1;
    check_eq("stall_if", {31'd0, stall_if}, {31'd0, if_req & ~exp_if_done});
    check_eq("stall_mem", {31'd0, stall_mem}, {31'd0, mem_req & ~exp_mem_done});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    check_regs();
    drive_cycle();
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    ram_rdata = 32'h0; ram_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst ram_req", {31'd0, ram_req}, 32'd0);
    check_eq("rst ram_we", {31'd0, ram_we}, 32'd0);
    check_eq("rst ram_addr", ram_addr, 32'd0);
    check_eq("rst ram_wdata", ram_wdata, 32'd0);
    check_eq("rst if_done", {31'd0, if_done}, 32'd0);
    check_eq("rst mem_done", {31'd0, mem_done}, 32'd0);
    check_eq("rst if_rdata", if_rdata, 32'd0);
    check_eq("rst mem_rdata", mem_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    cyc = 0;
    drive_cycle();

    repeat (3000) next_cycle();

    // quiesce: let outstanding requests finish with no new traffic
    gen_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!if_pend && !mem_pend && cyc >= free_at) break;
      next_cycle();
    end
    check_eq("drain", {31'd0, (!if_pend && !mem_pend && cyc >= free_at)}, 32'd1);

    // reset in the middle of a long data access
    mem_pend = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0300; mem_wdata = 32'h0;
    force_w = 5;
    repeat (4) next_cycle();
    check_eq("busy before reset", {31'd0, ram_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst mid ram_req", {31'd0, ram_req}, 32'd0);
    check_eq("rst mid mem_done", {31'd0, mem_done}, 32'd0);
    check_eq("rst mid if_done", {31'd0, if_done}, 32'd0);
    check_eq("rst mid ram_addr", ram_addr, 32'd0);
    #1;
    rst_n = 1'b1;
    // the still-pending data request is granted on the very next edge
    force_w = -1;
    t_who = 2; t_g = cyc; t_w = 1; t_we = 1'b0; t_drop = 1'b0;
    t_addr = 32'h0000_0300; t_data = $urandom;
    free_at = t_g + 3 + t_w;
    repeat (5) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
